rd_req_credit_scheduler: RTL and testbench

RD_REQ_CREDIT_SCHEDULER -- requirements
Module: rd_req_credit_scheduler

---
 rtl/rd_req_credit_scheduler.sv | 122 ++++++++++++
 tb/tb_rd_req_credit_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rd_req_credit_scheduler.sv
// rd_req_credit_scheduler
//   Round-robin arbiter for N memory-read requesters that share one completion
//   credit tracker. It picks a winner, holds it until the CH/CD credits and the
//   TX path are available, issues a single one-hot submit, and then waits two
//   gap cycles so the tracker can absorb the update before the next pick.
//
// Ports
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_Enable              allow a new arbitration to start
//   iv_ReqValid[N]        per-requester pending read, held until granted
//   iv_ReqCH[N][8]        CH credits each requester needs
//   iv_ReqCD[N][12]       CD credits each requester needs
//   i8_AvailCredCH        CH credits currently available
//   i12_AvailCredCD       CD credits currently available
//   i_TxReady             TLP transmit path can take a read request
//   ov_ReqGrant[N]        one-cycle one-hot grant
//   ov_MemRdReqSubmit[N]  one-cycle one-hot submit, same as grant
//   ov_MemRdReqCH/CD      winner's latched credits in its slot during submit
//   o_CredStall           winner is waiting on credits
module rd_req_credit_scheduler #(
  parameter int pREQUESTOR_NUM = 4
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic                                i_Enable,
  input  logic [pREQUESTOR_NUM-1:0]           iv_ReqValid,
  input  logic [pREQUESTOR_NUM-1:0][7:0]      iv_ReqCH,
  input  logic [pREQUESTOR_NUM-1:0][11:0]     iv_ReqCD,
  input  logic [7:0]                          i8_AvailCredCH,
  input  logic [11:0]                         i12_AvailCredCD,
  input  logic                                i_TxReady,
  output logic [pREQUESTOR_NUM-1:0]           ov_ReqGrant,
  output logic [pREQUESTOR_NUM-1:0]           ov_MemRdReqSubmit,
  output logic [pREQUESTOR_NUM-1:0][7:0]      ov_MemRdReqCH,
  output logic [pREQUESTOR_NUM-1:0][11:0]     ov_MemRdReqCD,
  output logic                                o_CredStall
);

  localparam int N  = pREQUESTOR_NUM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, GAP1, GAP2} state_t;

  state_t        rState, nState;
  logic [IW-1:0] rPtr, rWin, selIdx;
  logic [7:0]    rCH;
  logic [11:0]   rCD;
  logic          rStall;
  logic          credOk, winValid, startSel;
  logic [N-1:0]  grantVec;
  int            idxInt;

  assign winValid = iv_ReqValid[rWin];
  assign credOk   = (rCH <= i8_AvailCredCH) && (rCD <= i12_AvailCredCD);
  assign startSel = i_Enable && (|iv_ReqValid);

  // First valid index at or above rPtr, wrapping at N. Walking the offsets
  // from the far end down lets the smallest offset win by overwriting.
  always_comb begin
    selIdx = '0;
    idxInt = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idxInt = int'(rPtr) + k;
      if (idxInt >= N) idxInt = idxInt - N;
      if (iv_ReqValid[IW'(idxInt)]) selIdx = IW'(idxInt);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) rState <= IDLE;
    else       rState <= nState;
  end

  always_comb begin
    nState = rState;
    case (rState)
      IDLE:  if (startSel) nState = CHECK;
      // Winner is held here until it passes; nobody else may bypass it.
      CHECK: begin
        if (!winValid || !i_Enable)      nState = IDLE;
        else if (credOk && i_TxReady)    nState = ISSUE;
      end
      ISSUE: nState = GAP1;
      GAP1:  nState = GAP2;
      GAP2:  nState = IDLE;
      default: nState = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rPtr   <= '0;
      rWin   <= '0;
      rCH    <= '0;
      rCD    <= '0;
      rStall <= 1'b0;
    end else begin
      // Registered so it tracks the cycles spent waiting; a TxReady-only
      // hold does not count as a credit stall.
      rStall <= (rState == CHECK) && winValid && i_Enable && !credOk;
      if (rState == IDLE && startSel) begin
        rWin <= selIdx;
        rCH  <= iv_ReqCH[selIdx];
        rCD  <= iv_ReqCD[selIdx];
      end
      // Pointer only moves on a real issue; an aborted winner keeps its turn.
      if (rState == ISSUE)
        rPtr <= (rWin == IW'(N - 1)) ? '0 : rWin + IW'(1);
    end
  end

  for (genvar g = 0; g < N; g++) begin : gSlot
    assign grantVec[g]          = (rState == ISSUE) && (rWin == IW'(g));
    assign ov_ReqGrant[g]       = grantVec[g];
    assign ov_MemRdReqSubmit[g] = grantVec[g];
    assign ov_MemRdReqCH[g]     = grantVec[g] ? rCH : '0;
    assign ov_MemRdReqCD[g]     = grantVec[g] ? rCD : '0;
  end

  assign o_CredStall = rStall;

endmodule

// File: tb/tb_rd_req_credit_scheduler.sv
// Directed bench for rd_req_credit_scheduler (N=4). Inputs change 1 ns after
// each rising edge; outputs are checked at that same point.
module tb_rd_req_credit_scheduler;

  logic             clk = 1'b0;
  logic             rst, enable, txReady;
  logic [3:0]       valid;
  logic [3:0][7:0]  reqCH;
  logic [3:0][11:0] reqCD;
  logic [7:0]       availCH;
  logic [11:0]      availCD;
  logic [3:0]       grant, submit;
  logic [3:0][7:0]  outCH;
  logic [3:0][11:0] outCD;
  logic             stall;
  logic [3:0]       seen;

  int nChk  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  rd_req_credit_scheduler #(.pREQUESTOR_NUM(4)) dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Enable          (enable),
    .iv_ReqValid       (valid),
    .iv_ReqCH          (reqCH),
    .iv_ReqCD          (reqCD),
    .i8_AvailCredCH    (availCH),
    .i12_AvailCredCD   (availCD),
    .i_TxReady         (txReady),
    .ov_ReqGrant       (grant),
    .ov_MemRdReqSubmit (submit),
    .ov_MemRdReqCH     (outCH),
    .ov_MemRdReqCD     (outCD),
    .o_CredStall       (stall)
  );

  task automatic cyc(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every output against one expected grant vector and slot payload.
  task automatic chkOut(string tag, logic [3:0] eG, logic [7:0] eCH,
                        logic [11:0] eCD, logic eStall);
    logic [3:0][7:0]  xCH;
    logic [3:0][11:0] xCD;
    xCH = '0;
    xCD = '0;
    for (int i = 0; i < 4; i++)
      if (eG[i]) begin
        xCH[i] = eCH;
        xCD[i] = eCD;
      end
    chk({tag, ".grant"},  64'(grant),  64'(eG));
    chk({tag, ".submit"}, 64'(submit), 64'(eG));
    chk({tag, ".ch"},     64'(outCH),  64'(xCH));
    chk({tag, ".cd"},     64'(outCD),  64'(xCD));
    chk({tag, ".stall"},  64'(stall),  64'(eStall));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; txReady = 1'b0; valid = '0;
    reqCH = '0; reqCD = '0; availCH = '0; availCD = '0;
    cyc(2);
    chkOut("reset", 4'b0000, 8'd0, 12'd0, 1'b0);
    rst = 1'b0;

    // Single request on slot 2: grant two cycles after valid rises.
    availCH = 8'd8; availCD = 12'd64; txReady = 1'b1; enable = 1'b1;
    valid = 4'b0100; reqCH[2] = 8'd1; reqCD[2] = 12'd16;
    cyc(); chkOut("single.check", 4'b0000, 8'd0, 12'd0, 1'b0);
    cyc(); chkOut("single.issue", 4'b0100, 8'd1, 12'd16, 1'b0);
    valid = 4'b0000;
    cyc(); chkOut("single.gap1", 4'b0000, 8'd0, 12'd0, 1'b0);
    cyc(2);

    // Round robin from a fresh pointer, all four requesting.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin reqCH[i] = 8'd1; reqCD[i] = 12'd1; end
    valid = 4'b1111;
    cyc(); chk("rr.check", 64'(grant), 64'd0);
    cyc(); chkOut("rr.grant0", 4'b0001, 8'd1, 12'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      seen = '0;
      for (int c = 0; c < 4; c++) begin cyc(); seen |= grant; end
      chk($sformatf("rr.spacing%0d", k), 64'(seen), 64'd0);
      cyc(); chkOut($sformatf("rr.grant%0d", k), 4'(1 << (k % 4)), 8'd1, 12'd1, 1'b0);
    end
    valid = 4'b0000;
    cyc(3);

    // Credit stall on slot 1 (pointer now at 1).
    valid = 4'b0010; reqCD[1] = 12'd32; availCD = 12'd16;
    cyc(2); chkOut("stall.wait1", 4'b0000, 8'd0, 12'd0, 1'b1);
    cyc();  chkOut("stall.wait2", 4'b0000, 8'd0, 12'd0, 1'b1);
    availCD = 12'd32;
    cyc();  chkOut("stall.release", 4'b0010, 8'd1, 12'd32, 1'b0);
    valid = 4'b0000;
    cyc(3);

    // Abort: slot 2 stalls, drops valid; slot 3 must win next (pointer at 2).
    reqCD[2] = 12'd100; reqCD[3] = 12'd4;
    valid = 4'b1110;
    cyc(2); chkOut("abort.stall", 4'b0000, 8'd0, 12'd0, 1'b1);
    valid = 4'b1010;
    cyc();  chkOut("abort.idle", 4'b0000, 8'd0, 12'd0, 1'b0);
    cyc();  chk("abort.check", 64'(grant), 64'd0);
    cyc();  chkOut("abort.next", 4'b1000, 8'd1, 12'd4, 1'b0);

    // Pointer wrapped to 0: slot 1 wins after the 5-cycle spacing.
    valid = 4'b0010; reqCD[1] = 12'd4;
    seen = '0;
    for (int c = 0; c < 4; c++) begin cyc(); seen |= grant; end
    chk("rst.spacing", 64'(seen), 64'd0);
    cyc(); chkOut("rst.grant1", 4'b0010, 8'd1, 12'd4, 1'b0);

    // Reset while in GAP1; next arbitration restarts at slot 0.
    valid = 4'b1111;
    cyc(); rst = 1'b1;
    cyc(); chkOut("rst.gap1", 4'b0000, 8'd0, 12'd0, 1'b0);
    rst = 1'b0;
    cyc(); chk("rst.check", 64'(grant), 64'd0);
    cyc(); chkOut("rst.restart", 4'b0001, 8'd1, 12'd1, 1'b0);
    valid = 4'b0000;
    cyc(3);

    // TxReady low for 3 cycles in CHECK: no credit stall, grant right after.
    txReady = 1'b0; valid = 4'b0010;
    cyc();
    for (int c = 0; c < 3; c++) begin
      cyc(); chkOut($sformatf("tx.hold%0d", c), 4'b0000, 8'd0, 12'd0, 1'b0);
    end
    txReady = 1'b1;
    cyc(); chkOut("tx.grant", 4'b0010, 8'd1, 12'd4, 1'b0);
    valid = 4'b0000;
    cyc(3);

    // Zero-credit request passes with zero credits available.
    availCH = 8'd0; availCD = 12'd0;
    reqCH[2] = 8'd0; reqCD[2] = 12'd0; valid = 4'b0100;
    cyc(2); chkOut("zero.grant", 4'b0100, 8'd0, 12'd0, 1'b0);

    // Enable dropped right after issue: gaps finish, nothing new until enable.
    enable = 1'b0;
    seen = '0;
    for (int c = 0; c < 6; c++) begin cyc(); seen |= grant; end
    chk("en.quiet", 64'(seen), 64'd0);
    enable = 1'b1;
    cyc(); chk("en.check", 64'(grant), 64'd0);
    cyc(); chkOut("en.grant", 4'b0100, 8'd0, 12'd0, 1'b0);
    valid = 4'b0000;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
